// File: rtl/paddle_input_conditioner_pkg.sv
// Shared definitions for the tennis push-button conditioning path:
// debouncer state encodings, counter sizing and colour helpers.
package tennis_input_pkg;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd750000;
   localparam int unsigned DB_CNT_W                = 32'd20;
   localparam int unsigned COLOR_W                 = 32'd3;

   localparam logic [1:0] ST_RELEASED   = 2'd0;
   localparam logic [1:0] ST_PRESS_PEND = 2'd1;
   localparam logic [1:0] ST_PRESSED    = 2'd2;
   localparam logic [1:0] ST_REL_PEND   = 2'd3;

   typedef logic [COLOR_W-1:0]  color_t;
   typedef logic [DB_CNT_W-1:0] db_cnt_t;

   // A key counts as held while it is accepted or while its release is still unconfirmed.
   function automatic logic key_is_down(input logic [1:0] st);
      return (st == ST_PRESSED) || (st == ST_REL_PEND);
   endfunction

   function automatic color_t color_next(input color_t c);
      return c + 3'd1;
   endfunction

endpackage

// File: rtl/paddle_input_conditioner_if.sv
// Button-side and video-generator-side signals of the paddle conditioner.
// The key source drives through master, the conditioner sits on slave.
interface paddle_input_conditioner_if;
   import tennis_input_pkg::*;

   logic   keyUpN;
   logic   keyDownN;
   logic   keyColorN;
   logic   raket_up;
   logic   raket_down;
   color_t bgColor;
   logic   colorStep;

   modport master (
      output keyUpN,
      output keyDownN,
      output keyColorN,
      input  raket_up,
      input  raket_down,
      input  bgColor,
      input  colorStep
   );

   modport slave (
      input  keyUpN,
      input  keyDownN,
      input  keyColorN,
      output raket_up,
      output raket_down,
      output bgColor,
      output colorStep
   );

endinterface

// File: rtl/paddle_input_conditioner_key_debouncer.sv
// One push-button: two-flop synchroniser into pixelClock, then a four-state
// debouncer that only accepts a level after it has held for DEBOUNCE_CYCLES.
module key_debouncer
   import tennis_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic pixelClock,
   input  logic resetN,
   input  logic keyN,
   output logic db,
   output logic rise
);

   localparam db_cnt_t LP_CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam db_cnt_t LP_CNT_ONE  = {{(DB_CNT_W-1){1'b0}}, 1'b1};
   localparam db_cnt_t LP_CNT_ZERO = {DB_CNT_W{1'b0}};

   logic       r_sync1;
   logic       r_sync2;
   logic       w_raw;
   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   db_cnt_t    r_cnt;
   db_cnt_t    w_cnt_nxt;
   db_cnt_t    w_cnt_inc;
   logic       w_rise_nxt;
   logic       r_db;
   logic       r_rise;

   // Synchroniser flops rest at 1 so a reset looks like a released key.
   always_ff @(posedge pixelClock or negedge resetN) begin
      if (!resetN) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= keyN;
         r_sync2 <= r_sync1;
      end
   end

   assign w_raw     = ~r_sync2;
   assign w_cnt_inc = r_cnt + LP_CNT_ONE;

   // Next-state logic; the counter stops at LP_CNT_LAST so it cannot wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      case (r_state)
         ST_RELEASED: begin
            if (w_raw) begin
               w_state_nxt = ST_PRESS_PEND;
               w_cnt_nxt   = LP_CNT_ZERO;
            end else begin
               w_state_nxt = ST_RELEASED;
            end
         end
         ST_PRESS_PEND: begin
            if (!w_raw) begin
               w_state_nxt = ST_RELEASED;
            end else if (w_cnt_inc == LP_CNT_LAST) begin
               w_state_nxt = ST_PRESSED;
               w_cnt_nxt   = w_cnt_inc;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         ST_PRESSED: begin
            if (!w_raw) begin
               w_state_nxt = ST_REL_PEND;
               w_cnt_nxt   = LP_CNT_ZERO;
            end else begin
               w_state_nxt = ST_PRESSED;
            end
         end
         ST_REL_PEND: begin
            if (w_raw) begin
               w_state_nxt = ST_PRESSED;
            end else if (w_cnt_inc == LP_CNT_LAST) begin
               w_state_nxt = ST_RELEASED;
               w_cnt_nxt   = w_cnt_inc;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = ST_RELEASED;
            w_cnt_nxt   = LP_CNT_ZERO;
         end
      endcase
   end

   // State, counter and registered db/rise; db follows the state being entered.
   always_ff @(posedge pixelClock or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_RELEASED;
         r_cnt   <= LP_CNT_ZERO;
         r_db    <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_db    <= key_is_down(w_state_nxt);
         r_rise  <= w_rise_nxt;
      end
   end

   assign db   = r_db;
   assign rise = r_rise;

endmodule

// File: rtl/paddle_input_conditioner.sv
// Debounces the three paddle/colour buttons and produces the paddle move
// levels (never both at once) and the stepped background colour.
module paddle_input_conditioner
   import tennis_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter color_t      RESET_COLOR     = 3'b000
) (
   input  logic                       pixelClock,
   input  logic                       resetN,
   paddle_input_conditioner_if.slave  bus
);

   logic   w_db_up;
   logic   w_db_down;
   logic   w_db_color;
   logic   w_rise_up;
   logic   w_rise_down;
   logic   w_rise_color;
   logic   w_unused_key_status;
   logic   r_raket_up;
   logic   r_raket_down;
   color_t r_bg_color;
   logic   r_color_step;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
      .pixelClock (pixelClock),
      .resetN     (resetN),
      .keyN       (bus.keyUpN),
      .db         (w_db_up),
      .rise       (w_rise_up)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
      .pixelClock (pixelClock),
      .resetN     (resetN),
      .keyN       (bus.keyDownN),
      .db         (w_db_down),
      .rise       (w_rise_down)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_color (
      .pixelClock (pixelClock),
      .resetN     (resetN),
      .keyN       (bus.keyColorN),
      .db         (w_db_color),
      .rise       (w_rise_color)
   );

   // Paddle moves follow the held level; only the colour key needs its press edge.
   assign w_unused_key_status = w_rise_up ^ w_rise_down ^ w_db_color;

   // Up/down arbitration: opposing requests cancel each other.
   always_ff @(posedge pixelClock or negedge resetN) begin
      if (!resetN) begin
         r_raket_up   <= 1'b0;
         r_raket_down <= 1'b0;
      end else begin
         r_raket_up   <= w_db_up & ~w_db_down;
         r_raket_down <= w_db_down & ~w_db_up;
      end
   end

   // Background colour steps once per accepted colour press, wrapping mod 8.
   always_ff @(posedge pixelClock or negedge resetN) begin
      if (!resetN) begin
         r_bg_color   <= RESET_COLOR;
         r_color_step <= 1'b0;
      end else begin
         r_color_step <= w_rise_color;
         if (w_rise_color) begin
            r_bg_color <= color_next(r_bg_color);
         end else begin
            r_bg_color <= r_bg_color;
         end
      end
   end

   assign bus.raket_up   = r_raket_up;
   assign bus.raket_down = r_raket_down;
   assign bus.bgColor    = r_bg_color;
   assign bus.colorStep  = r_color_step;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Table-driven bench for paddle_input_conditioner: each vector pushes its expected
// outputs into a scoreboard due 10 edges after capture; a monitor checks every cycle.
`timescale 1ns/1ps
module tb_paddle_input_conditioner;
   import tennis_input_pkg::*;

   localparam int unsigned DB      = 8;
   localparam color_t      RST_COL = 3'b010;
   // Drive at a negedge; capture is the next posedge (edge 0); outputs move at edge 10.
   localparam int          LAT     = 11;

   typedef struct {
      int     due;
      logic   up;
      logic   down;
      color_t color;
      logic   step;
   } exp_t;

   typedef struct {
      logic   up_n;
      logic   down_n;
      logic   color_n;
      int     hold;
      logic   up;
      logic   down;
      color_t color;
   } vec_t;

   logic pixelClock = 1'b0;
   logic resetN;
   paddle_input_conditioner_if bus ();

   paddle_input_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .RESET_COLOR     (RST_COL)
   ) dut (
      .pixelClock (pixelClock),
      .resetN     (resetN),
      .bus        (bus)
   );

   always #5 pixelClock = ~pixelClock;

   exp_t sb[$];
   exp_t cur;
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 1'b0;

   always @(posedge pixelClock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic chk_outputs(input string tag, input exp_t e);
      chk({tag, " raket_up"},   int'(bus.raket_up),   int'(e.up));
      chk({tag, " raket_down"}, int'(bus.raket_down), int'(e.down));
      chk({tag, " bgColor"},    int'(bus.bgColor),    int'(e.color));
      chk({tag, " colorStep"},  int'(bus.colorStep),  int'(e.step));
   endtask

   // Per-cycle monitor: the expectation switches on the cycle an entry falls due.
   always @(negedge pixelClock) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due == cyc) cur = sb.pop_front();
         else cur.step = 1'b0;
         chk_outputs("mon", cur);
      end
   end

   function automatic vec_t v(input logic u, input logic d, input logic c, input int h,
                              input logic eu, input logic ed, input color_t ec);
      vec_t r;
      r.up_n = u; r.down_n = d; r.color_n = c; r.hold = h;
      r.up = eu; r.down = ed; r.color = ec;
      return r;
   endfunction

   task automatic drive(input vec_t x, input color_t prev_color);
      exp_t e;
      @(negedge pixelClock);
      bus.keyUpN    = x.up_n;
      bus.keyDownN  = x.down_n;
      bus.keyColorN = x.color_n;
      e.due   = cyc + LAT;
      e.up    = x.up;
      e.down  = x.down;
      e.color = x.color;
      e.step  = (x.color != prev_color);
      sb.push_back(e);
      repeat (x.hold - 1) @(negedge pixelClock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t   vecs[$];
      exp_t   e;
      color_t prev_color;

      // clean press / release of up
      vecs.push_back(v(1'b0, 1'b1, 1'b1, 20, 1'b1, 1'b0, 3'b010));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 20, 1'b0, 1'b0, 3'b010));
      // bouncing down key: 3 low / 2 high five times, then stable low
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(v(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 3'b010));
         vecs.push_back(v(1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 3'b010));
      end
      vecs.push_back(v(1'b1, 1'b0, 1'b1, 20, 1'b0, 1'b1, 3'b010));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 20, 1'b0, 1'b0, 3'b010));
      // both keys together, then down released while up held
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b0, 3'b010));
      vecs.push_back(v(1'b0, 1'b1, 1'b1, 20, 1'b1, 1'b0, 3'b010));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 20, 1'b0, 1'b0, 3'b010));
      // six colour presses: 3,4,5,6,7,0
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 14, 1'b0, 1'b0, 3'b011));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b011));
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 14, 1'b0, 1'b0, 3'b100));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b100));
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 14, 1'b0, 1'b0, 3'b101));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b101));
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 14, 1'b0, 1'b0, 3'b110));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b110));
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 14, 1'b0, 1'b0, 3'b111));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b111));
      vecs.push_back(v(1'b1, 1'b1, 1'b0, 14, 1'b0, 1'b0, 3'b000));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b000));
      // colour and up pressed together update in the same cycle
      vecs.push_back(v(1'b0, 1'b1, 1'b0, 14, 1'b1, 1'b0, 3'b001));
      vecs.push_back(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b001));

      // reset with all keys released
      resetN        = 1'b0;
      bus.keyUpN    = 1'b1;
      bus.keyDownN  = 1'b1;
      bus.keyColorN = 1'b1;
      cur.due = 0; cur.up = 1'b0; cur.down = 1'b0; cur.color = RST_COL; cur.step = 1'b0;
      repeat (3) @(negedge pixelClock);
      chk_outputs("reset", cur);
      resetN = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(negedge pixelClock);

      prev_color = RST_COL;
      foreach (vecs[i]) begin
         drive(vecs[i], prev_color);
         prev_color = vecs[i].color;
      end
      repeat (2) @(negedge pixelClock);

      // reset mid-debounce: colour key low for 5 clocks, reset while still held
      @(negedge pixelClock);
      bus.keyColorN = 1'b0;
      repeat (4) @(negedge pixelClock);
      mon_en = 1'b0;
      #2 resetN = 1'b0;
      #1;
      e.due = 0; e.up = 1'b0; e.down = 1'b0; e.color = RST_COL; e.step = 1'b0;
      chk_outputs("async reset", e);
      repeat (3) begin
         @(negedge pixelClock);
         chk_outputs("in reset", e);
      end
      sb.delete();
      cur = e;
      resetN = 1'b1;
      e.due   = cyc + LAT;
      e.color = 3'b011;
      e.step  = 1'b1;
      sb.push_back(e);
      mon_en = 1'b1;
      repeat (16) @(negedge pixelClock);
      drive(v(1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b0, 3'b011), 3'b011);
      repeat (2) @(negedge pixelClock);
      mon_en = 1'b0;

      chk("scoreboard drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/paddle_input_conditioner.md
# paddle_input_conditioner

Conditions the raw DE2-115 push-buttons that drive the tennis video generator and produces its `raket_up`, `raket_down` and `bgColor` inputs. Each button is synchronised into the pixel-clock domain and debounced by a four-state machine. Up/down requests are arbitrated so they are never asserted together. A third button steps the background colour on each debounced press.

## Interface
- `DEBOUNCE_CYCLES`, default 750000: clocks a level must hold before it is accepted (10 ms at 75 MHz); legal range 2..2^20−1.
- `RESET_COLOR`, default 3'b000: `bgColor` value after reset.
- `pixelClock`  in  1  75 MHz pixel clock; the only clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `keyUpN`  in  1  raw paddle-up button, active-low, asynchronous to `pixelClock`.
- `keyDownN`  in  1  raw paddle-down button, active-low, asynchronous.
- `keyColorN`  in  1  raw colour-step button, active-low, asynchronous.
- `raket_up`  out  1  registered level: move paddle up.
- `raket_down`  out  1  registered level: move paddle down.
- `bgColor`  out  3  registered background colour index.
- `colorStep`  out  1  one-cycle pulse when `bgColor` changes.

## Operation
- **Synchroniser**
  - Each raw key passes through a 2-flop synchroniser, reset to 1 (released).
  - The inverted result gives the active-high `raw_i`.
- **Debouncer states**, one per key: RELEASED, PRESS_PEND, PRESSED, REL_PEND. Reset state is RELEASED with the counter at 0.
  - RELEASED: `raw_i`=1 → PRESS_PEND, counter cleared.
  - PRESS_PEND: `raw_i`=0 → RELEASED. Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`−1 → PRESSED, and a one-cycle `rise` pulse is emitted.
  - PRESSED: `raw_i`=0 → REL_PEND, counter cleared.
  - REL_PEND: `raw_i`=1 → PRESSED. At count `DEBOUNCE_CYCLES`−1 → RELEASED.
  - The debounced level `db` = 1 in PRESSED and REL_PEND.
  - The counter is 20 bits, saturates by construction and never wraps.
- **Arbitration**, registered:
  - `raket_up` <= `db_up` & ~`db_down`.
  - `raket_down` <= `db_down` & ~`db_up`.
  - Both pressed → both 0.
- **Colour**
  - On `rise` of the colour key, `bgColor` <= `bgColor`+1, mod 8, so 3'b111 wraps to 3'b000.
  - `colorStep` is 1 for that same cycle only; otherwise 0.
- **Reset**
  - Asserting `resetN`=0 at any time, including mid-debounce, immediately forces every flop to its reset value.
  - After deassertion all keys restart from RELEASED. A key held through reset is accepted after the full debounce period.
- **Reset values**: `raket_up`=0, `raket_down`=0, `bgColor`=`RESET_COLOR`, `colorStep`=0.

## Timing
- Let edge 0 be the first `pixelClock` edge at which the first synchroniser flop captures the new key level, with the level stable afterwards.
- `raw_i` changes after edge 1.
- The debouncer reaches PRESSED at edge 1+`DEBOUNCE_CYCLES`.
- `raket_up`/`raket_down`/`bgColor`/`colorStep` change at edge 2+`DEBOUNCE_CYCLES`. Press and release latency are equal.
- A glitch shorter than `DEBOUNCE_CYCLES` clocks at the debouncer input produces no output change.
- A glitch at the synchroniser input that the first flop never samples is invisible.
- Simultaneous `rise` on up and down in the same cycle → both outputs stay 0.
- A colour press while up/down change: the two paths are independent and both update in the same cycle.

## Structure
- Shared package `tennis_input_pkg` holds:
  - debouncer state encodings (2-bit: RELEASED=0, PRESS_PEND=1, PRESSED=2, REL_PEND=3);
  - the default `DEBOUNCE_CYCLES`;
  - the counter width of 20.
- Sub-module `key_debouncer` (synchroniser + FSM + counter; ports `pixelClock`, `resetN`, `keyN`, `db`, `rise`; parameter `DEBOUNCE_CYCLES`), instantiated three times.
- Top level holds only the arbitration and colour registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8 and `RESET_COLOR`=3'b010.
- **Reset**: `resetN` low, all keys high → `raket_up`=0, `raket_down`=0, `bgColor`=3'b010, `colorStep`=0. Release reset → outputs hold.
- **Clean press/release**: `keyUpN` low, held 20 clocks, then high.
  - `raket_up` rises exactly 10 edges after first capture.
  - `raket_up` falls 10 edges after release is captured.
  - `raket_down` stays 0.
- **Bounce**: `keyDownN` toggles low for 3 clocks, high for 2, repeated 5×, then stays low → `raket_down` rises exactly 10 edges after the final stable low is captured, with no earlier pulse.
- **Both keys**: `keyUpN` and `keyDownN` go low on the same edge and are held → both outputs remain 0. Release `keyDownN` → `raket_up`=1 after 10 edges.
- **Colour wrap**: six clean `keyColorN` presses → `bgColor` steps 3, 4, 5, 6, 7, 0. `colorStep` pulses exactly once per press, each pulse 1 cycle wide.
- **Reset mid-debounce**: `keyColorN` low for 5 clocks, then `resetN` pulsed low while the key is still held.
  - Outputs return to reset values immediately, with no `colorStep`.
  - The held key yields `bgColor`=3'b011 exactly 10 edges after reset release.
